// File: rtl/tensor_block_sequencer_if.sv
// Command and weight/activation handshake bundle between the tile scheduler
// (master) and one tensor_block_sequencer (slave).
interface tensor_block_sequencer_if #(
    parameter int CHUNK_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_num_w;
    logic [CHUNK_W-1:0] cmd_num_chunks;
    logic               cmd_bank_sel;
    logic               cmd_w_from_cascade;
    logic               w_valid;
    logic               w_ready;
    logic               a_valid;
    logic               a_ready;

    modport master (
        output cmd_valid, cmd_num_w, cmd_num_chunks, cmd_bank_sel, cmd_w_from_cascade,
        output w_valid, a_valid,
        input  cmd_ready, w_ready, a_ready
    );

    modport slave (
        input  cmd_valid, cmd_num_w, cmd_num_chunks, cmd_bank_sel, cmd_w_from_cascade,
        input  w_valid, a_valid,
        output cmd_ready, w_ready, a_ready
    );
endinterface

// File: rtl/tensor_block_sequencer.sv
// Command sequencer for one int8 tensor block: weight load, activation streaming
// and result tagging. Define TENSOR_SEQ_PERF_EN to add busy/stall counters.
module tensor_block_sequencer #(
    parameter int CHUNK_W     = 8,
    parameter int DOT_LATENCY = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    tensor_block_sequencer_if.slave  bus,
    output logic                     mux1_select,
    output logic                     dot_unit_input_1_enable,
    output logic                     bank0_data_in_enable,
    output logic                     bank1_data_in_enable,
    output logic                     cascade_out_select,
    output logic                     dot_unit_input_2_select,
    output logic [2:0]               accumulator_input1_select,
    output logic                     out_valid,
    output logic                     cmd_done,
    output logic                     err_underrun
`ifdef TENSOR_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_busy_cycles,
    output logic [31:0]              perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

    state_t                       state_q, state_d;
    logic [1:0]                   num_w_q, num_w_d;
    logic [CHUNK_W-1:0]           num_chunks_q, num_chunks_d;
    logic                         bank_sel_q, bank_sel_d;
    logic                         w_casc_q, w_casc_d;
    logic [1:0]                   w_cnt_q, w_cnt_d;
    logic [CHUNK_W-1:0]           a_cnt_q, a_cnt_d;
    tag_t [DOT_LATENCY-1:0]       tag_q, tag_d;
    logic                         out_valid_q, out_valid_d;
    logic [2:0]                   acc_sel_q, acc_sel_d;
    logic                         cmd_done_q, cmd_done_d;
    logic                         err_q, err_d;

    logic                         w_beat;
    logic                         a_beat;
    logic                         a_last;
    tag_t                         tag_in;
    tag_t                         tag_out;

    assign w_beat  = (state_q == S_LOAD) && bus.w_valid;
    assign a_beat  = (state_q == S_STREAM) && bus.a_valid;
    assign a_last  = (a_cnt_q == num_chunks_q - CHUNK_W'(1));
    assign tag_out = tag_q[DOT_LATENCY-1];

    always_comb begin
        state_d      = state_q;
        num_w_d      = num_w_q;
        num_chunks_d = num_chunks_q;
        bank_sel_d   = bank_sel_q;
        w_casc_d     = w_casc_q;
        w_cnt_d      = w_cnt_q;
        a_cnt_d      = a_cnt_q;
        err_d        = err_q;
        cmd_done_d   = 1'b0;

        tag_in.vld   = a_beat;
        tag_in.first = a_beat && (a_cnt_q == '0);
        tag_in.last  = a_beat && a_last;
        tag_d        = {tag_q[DOT_LATENCY-2:0], tag_in};

        // Output flop is the final pipe stage, so outputs land at accept + 1 + DOT_LATENCY.
        out_valid_d  = tag_out.vld && tag_out.last;
        acc_sel_d    = (tag_out.vld && tag_out.first) ? 3'b000 : 3'b111;

        case (state_q)
            S_IDLE: begin
                // cmd_done_q marks the pulse cycle, during which no command is taken.
                if (bus.cmd_valid && !cmd_done_q) begin
                    num_w_d      = bus.cmd_num_w;
                    num_chunks_d = bus.cmd_num_chunks;
                    bank_sel_d   = bus.cmd_bank_sel;
                    w_casc_d     = bus.cmd_w_from_cascade;
                    w_cnt_d      = '0;
                    a_cnt_d      = '0;
                    if (bus.cmd_num_w != 2'd0)
                        state_d = S_LOAD;
                    else if (bus.cmd_num_chunks != '0)
                        state_d = S_STREAM;
                    else
                        cmd_done_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.w_valid) begin
                    w_cnt_d = w_cnt_q + 2'd1;
                    if (w_cnt_q == num_w_q - 2'd1) begin
                        if (num_chunks_q != '0) begin
                            state_d = S_STREAM;
                        end else begin
                            state_d    = S_IDLE;
                            cmd_done_d = 1'b1;
                        end
                    end
                end
            end
            S_STREAM: begin
                if (bus.a_valid) begin
                    a_cnt_d = a_cnt_q + CHUNK_W'(1);
                    if (a_last)
                        state_d = S_DRAIN;
                end else if (a_cnt_q != '0) begin
                    err_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tag_out.vld && tag_out.last) begin
                    state_d    = S_IDLE;
                    cmd_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            num_w_q      <= '0;
            num_chunks_q <= '0;
            bank_sel_q   <= 1'b0;
            w_casc_q     <= 1'b0;
            w_cnt_q      <= '0;
            a_cnt_q      <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            acc_sel_q    <= 3'b000;
            cmd_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_w_q      <= num_w_d;
            num_chunks_q <= num_chunks_d;
            bank_sel_q   <= bank_sel_d;
            w_casc_q     <= w_casc_d;
            w_cnt_q      <= w_cnt_d;
            a_cnt_q      <= a_cnt_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            acc_sel_q    <= acc_sel_d;
            cmd_done_q   <= cmd_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.cmd_ready              = (state_q == S_IDLE) && !cmd_done_q;
    assign bus.w_ready                = (state_q == S_LOAD);
    assign bus.a_ready                = (state_q == S_STREAM);
    assign bank0_data_in_enable       = w_beat && !bank_sel_q;
    assign bank1_data_in_enable       = w_beat && bank_sel_q;
    assign dot_unit_input_1_enable    = a_beat;
    assign mux1_select                = w_casc_q;
    assign cascade_out_select         = bank_sel_q;
    assign dot_unit_input_2_select    = bank_sel_q;
    assign accumulator_input1_select  = acc_sel_q;
    assign out_valid                  = out_valid_q;
    assign cmd_done                   = cmd_done_q;
    assign err_underrun               = err_q;

`ifdef TENSOR_SEQ_PERF_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] stall_q, stall_d;
    logic        stall_now;

    assign stall_now = ((state_q == S_LOAD) && !bus.w_valid) ||
                       ((state_q == S_STREAM) && !bus.a_valid);

    always_comb begin
        busy_d  = busy_q;
        stall_d = stall_q;
        if ((state_q != S_IDLE) && (busy_q != 32'hFFFF_FFFF))
            busy_d = busy_q + 32'd1;
        if (stall_now && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign perf_busy_cycles  = busy_q;
    assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tensor_block_sequencer.sv
// Randomized bench for tensor_block_sequencer: per-command timelines are laid out
// from the command/beat schedule and compared cycle by cycle against the DUT.
module tb_tensor_block_sequencer;

    localparam int MAXC = 2500;
    localparam int LAT  = 6;   // accept-to-output latency: 1 + DOT_LATENCY

    logic clk;
    logic resetn;

    tensor_block_sequencer_if #(.CHUNK_W(8)) bus ();

    logic       mux1_select;
    logic       dot_unit_input_1_enable;
    logic       bank0_data_in_enable;
    logic       bank1_data_in_enable;
    logic       cascade_out_select;
    logic       dot_unit_input_2_select;
    logic [2:0] accumulator_input1_select;
    logic       out_valid;
    logic       cmd_done;
    logic       err_underrun;
`ifdef TENSOR_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    tensor_block_sequencer #(.CHUNK_W(8), .DOT_LATENCY(5)) dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .bus                       (bus),
        .mux1_select               (mux1_select),
        .dot_unit_input_1_enable   (dot_unit_input_1_enable),
        .bank0_data_in_enable      (bank0_data_in_enable),
        .bank1_data_in_enable      (bank1_data_in_enable),
        .cascade_out_select        (cascade_out_select),
        .dot_unit_input_2_select   (dot_unit_input_2_select),
        .accumulator_input1_select (accumulator_input1_select),
        .out_valid                 (out_valid),
        .cmd_done                  (cmd_done),
        .err_underrun              (err_underrun)
`ifdef TENSOR_SEQ_PERF_EN
        ,
        .perf_busy_cycles          (perf_busy_cycles),
        .perf_stall_cycles         (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus per cycle
    bit       s_cmdv [MAXC];
    bit [1:0] s_nw   [MAXC];
    bit [7:0] s_nc   [MAXC];
    bit       s_bank [MAXC];
    bit       s_casc [MAXC];
    bit       s_wv   [MAXC];
    bit       s_av   [MAXC];
    // expectations per cycle
    bit e_ready [MAXC];
    bit e_wrdy  [MAXC];
    bit e_ardy  [MAXC];
    bit e_b0    [MAXC];
    bit e_b1    [MAXC];
    bit e_dot1  [MAXC];
    bit e_mux1  [MAXC];
    bit e_bsel  [MAXC];
    bit e_first [MAXC];
    bit e_out   [MAXC];
    bit e_done  [MAXC];
    int err_from;
    int m_busy;
    int m_stall;
    int cur;
    int cyc;

    int n_total;
    int n_bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic init_model();
        for (int k = 0; k < MAXC; k++) begin
            s_cmdv[k] = 1'($urandom);
            s_nw[k]   = 2'($urandom);
            s_nc[k]   = 8'($urandom);
            s_bank[k] = 1'($urandom);
            s_casc[k] = 1'($urandom);
            s_wv[k]   = 1'($urandom);
            s_av[k]   = 1'($urandom);
            e_ready[k] = 1'b1;
            e_wrdy[k] = 0; e_ardy[k] = 0; e_b0[k] = 0; e_b1[k] = 0; e_dot1[k] = 0;
            e_mux1[k] = 0; e_bsel[k] = 0; e_first[k] = 0; e_out[k] = 0; e_done[k] = 0;
        end
        err_from = -1;
        m_busy   = 0;
        m_stall  = 0;
        cur      = 0;
    endtask

    // mode -1: random 0..2 idle cycles before each beat; mode >= 0: one idle cycle before that beat only
    function automatic int gap_for(input int mode, input int idx);
        if (mode == -1) return $urandom_range(0, 2);
        return (mode == idx) ? 1 : 0;
    endfunction

    task automatic sched(input int nw, input int nc, input bit bank, input bit casc,
                         input int wmode, input int amode);
        int g, c, p, t;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin s_cmdv[cur] = 0; cur++; end
        c = cur;
        s_cmdv[c] = 1; s_nw[c] = 2'(nw); s_nc[c] = 8'(nc); s_bank[c] = bank; s_casc[c] = casc;
        for (int k = c + 1; k < MAXC; k++) begin e_mux1[k] = casc; e_bsel[k] = bank; end
        p = c + 1;
        if (nw == 0 && nc == 0) begin
            e_done[p] = 1; e_ready[p] = 0; cur = p + 1;
            return;
        end
        for (int i = 0; i < nw; i++) begin
            g = gap_for(wmode, i);
            for (int j = 0; j < g; j++) begin
                s_wv[p] = 0; e_wrdy[p] = 1; e_ready[p] = 0; m_busy++; m_stall++; p++;
            end
            s_wv[p] = 1; e_wrdy[p] = 1; e_ready[p] = 0; m_busy++;
            e_b0[p] = !bank; e_b1[p] = bank; p++;
        end
        if (nc == 0) begin
            e_done[p] = 1; e_ready[p] = 0; cur = p + 1;
            return;
        end
        t = p;
        for (int i = 0; i < nc; i++) begin
            g = gap_for(amode, i);
            for (int j = 0; j < g; j++) begin
                s_av[p] = 0; e_ardy[p] = 1; e_ready[p] = 0; m_busy++; m_stall++;
                if (i > 0 && err_from < 0) err_from = p + 1;
                p++;
            end
            s_av[p] = 1; e_ardy[p] = 1; e_dot1[p] = 1; e_ready[p] = 0; m_busy++;
            if (i == 0) e_first[p + LAT] = 1;
            t = p;
            p++;
        end
        for (int k = t + 1; k < t + LAT; k++) begin e_ready[k] = 0; m_busy++; end
        e_out[t + LAT] = 1; e_done[t + LAT] = 1; e_ready[t + LAT] = 0;
        cur = t + LAT + 1;
    endtask

    task automatic add_tail();
        for (int i = 0; i < 10; i++) begin s_cmdv[cur] = 0; cur++; end
    endtask

    task automatic run_phase(input int len);
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            bus.cmd_valid          = s_cmdv[k];
            bus.cmd_num_w          = s_nw[k];
            bus.cmd_num_chunks     = s_nc[k];
            bus.cmd_bank_sel       = s_bank[k];
            bus.cmd_w_from_cascade = s_casc[k];
            bus.w_valid            = s_wv[k];
            bus.a_valid            = s_av[k];
            @(negedge clk);
            cyc = k;
            check_val("cmd_ready", bus.cmd_ready, e_ready[k]);
            check_val("w_ready", bus.w_ready, e_wrdy[k]);
            check_val("a_ready", bus.a_ready, e_ardy[k]);
            check_val("bank0_en", bank0_data_in_enable, e_b0[k]);
            check_val("bank1_en", bank1_data_in_enable, e_b1[k]);
            check_val("dot1_en", dot_unit_input_1_enable, e_dot1[k]);
            check_val("mux1_sel", mux1_select, e_mux1[k]);
            check_val("casc_out_sel", cascade_out_select, e_bsel[k]);
            check_val("dot2_sel", dot_unit_input_2_select, e_bsel[k]);
            check_val("acc_sel", accumulator_input1_select, e_first[k] ? 3'b000 : 3'b111);
            check_val("out_valid", out_valid, e_out[k]);
            check_val("cmd_done", cmd_done, e_done[k]);
            check_val("err_underrun", err_underrun, (err_from >= 0 && k >= err_from) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic drive_idle();
        bus.cmd_valid = 0; bus.cmd_num_w = 0; bus.cmd_num_chunks = 0;
        bus.cmd_bank_sel = 0; bus.cmd_w_from_cascade = 0; bus.w_valid = 0; bus.a_valid = 0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst cmd_ready", bus.cmd_ready, 1'b1);
        check_val("rst w_ready", bus.w_ready, 1'b0);
        check_val("rst a_ready", bus.a_ready, 1'b0);
        check_val("rst bank0_en", bank0_data_in_enable, 1'b0);
        check_val("rst bank1_en", bank1_data_in_enable, 1'b0);
        check_val("rst dot1_en", dot_unit_input_1_enable, 1'b0);
        check_val("rst mux1_sel", mux1_select, 1'b0);
        check_val("rst casc_out_sel", cascade_out_select, 1'b0);
        check_val("rst dot2_sel", dot_unit_input_2_select, 1'b0);
        check_val("rst acc_sel", accumulator_input1_select, 3'b000);
        check_val("rst out_valid", out_valid, 1'b0);
        check_val("rst cmd_done", cmd_done, 1'b0);
        check_val("rst err_underrun", err_underrun, 1'b0);
`ifdef TENSOR_SEQ_PERF_EN
        check_val("rst perf_busy", perf_busy_cycles, 32'd0);
        check_val("rst perf_stall", perf_stall_cycles, 32'd0);
`endif
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        cyc     = -1;
        resetn  = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        resetn = 1'b1;

        // phase 1: directed commands from the plan, then random traffic
        init_model();
        sched(3, 1, 1'b0, 1'b0, -2, -2);
        sched(0, 4, 1'b1, 1'b1, -2, -2);
        sched(0, 0, 1'b0, 1'b1, -2, -2);
        sched(0, 3, 1'b0, 1'b0, -2, 2);
        for (int i = 0; i < 40 && cur < MAXC - 120; i++)
            sched($urandom_range(0, 3), $urandom_range(0, 8), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 0) ? -1 : -2,
                  ($urandom_range(0, 3) == 0) ? -1 : -2);
        add_tail();
        run_phase(cur);
`ifdef TENSOR_SEQ_PERF_EN
        check_val("perf_busy phase1", perf_busy_cycles, 32'(m_busy));
        check_val("perf_stall phase1", perf_stall_cycles, 32'(m_stall));
`endif

        // reset in the middle of a 5-chunk stream after 2 beats
        @(posedge clk); #1;
        drive_idle();
        bus.cmd_valid = 1; bus.cmd_num_chunks = 8'd5; bus.cmd_bank_sel = 1; bus.cmd_w_from_cascade = 1;
        @(posedge clk); #1;
        drive_idle();
        bus.a_valid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        cyc = -2;
        check_val("mid stream a_ready", bus.a_ready, 1'b1);
        check_val("mid stream dot2_sel", dot_unit_input_2_select, 1'b1);
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        bus.a_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cyc = -3 - k;
            check_val("post reset out_valid", out_valid, 1'b0);
            check_val("post reset cmd_done", cmd_done, 1'b0);
        end

        // phase 2: one command with a weight gap, contiguous activations
        init_model();
        sched(2, 2, 1'b1, 1'b0, 1, -2);
        add_tail();
        run_phase(cur);
`ifdef TENSOR_SEQ_PERF_EN
        check_val("perf_busy phase2", perf_busy_cycles, 32'(m_busy));
        check_val("perf_stall phase2", perf_stall_cycles, 32'(m_stall));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
